// File: rtl/vector_lane_engine.sv
// Vector load/store/ADD/SUB sequencer. Moves one lane per cycle between
// byte-addressed memory and a LANES x DATA_W result register.
module vector_lane_engine #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int SATURATE = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [1:0]                i_op,
    input  logic [ADDR_W-1:0]         i_base_addr,
    input  logic [LANES*DATA_W-1:0]   i_vsrc1,
    input  logic [LANES*DATA_W-1:0]   i_vsrc2,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_rden,
    output logic                      o_mem_wren,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_q,
    output logic                      o_busy,
    output logic                      o_vwrite,
    output logic [LANES*DATA_W-1:0]   o_vresult,
    output logic                      o_vzero,
    output logic                      o_done
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_ADD = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_LAST, S_WR, S_ALU, S_FIN} state_t;

    state_t                    r_state, w_next;
    logic [1:0]                r_op;
    logic [ADDR_W-1:0]         r_base;
    logic [LANES*DATA_W-1:0]   r_a, r_b, r_stage, r_vresult;
    logic                      r_vzero;
    logic [IDX_W-1:0]          r_idx, r_cap_idx;
    logic                      r_cap_vld;

    logic                      w_last;
    logic [ADDR_W-1:0]         w_addr;
    logic [DATA_W-1:0]         w_a_lane [LANES];
    logic [LANES*DATA_W-1:0]   w_alu, w_load_vec;

    assign w_last = (r_idx == IDX_W'(LANES - 1));
    assign w_addr = r_base + ADDR_W'(r_idx);

    // Per-lane datapath: no carry/borrow crosses a lane boundary.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W:0] w_sum, w_diff;
        assign w_a_lane[k] = r_a[k*DATA_W +: DATA_W];
        assign w_sum  = {1'b0, r_a[k*DATA_W +: DATA_W]} + {1'b0, r_b[k*DATA_W +: DATA_W]};
        assign w_diff = {1'b0, r_a[k*DATA_W +: DATA_W]} - {1'b0, r_b[k*DATA_W +: DATA_W]};
        always_comb begin
            if (r_op == OP_ADD)
                w_alu[k*DATA_W +: DATA_W] = (SATURATE != 0 && w_sum[DATA_W])
                                            ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
            else
                w_alu[k*DATA_W +: DATA_W] = (SATURATE != 0 && w_diff[DATA_W])
                                            ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
        end
        // Merges the lane arriving on mem_q into the staged vector.
        assign w_load_vec[k*DATA_W +: DATA_W] = (r_cap_idx == IDX_W'(k))
                                                ? i_mem_q : r_stage[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) begin
                           case (i_op)
                               OP_LOAD:  w_next = S_RD;
                               OP_STORE: w_next = S_WR;
                               default:  w_next = S_ALU;
                           endcase
                       end
            S_RD:      if (w_last) w_next = S_RD_LAST;
            S_RD_LAST: w_next = S_FIN;
            S_WR:      if (w_last) w_next = S_FIN;
            S_ALU:     w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so a reset cycle never issues a memory access.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_rden  = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_wdata = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_vwrite    = 1'b0;
        case (r_state)
            S_RD: begin
                o_busy     = 1'b1;
                o_mem_rden = ~i_reset;
                o_mem_addr = w_addr;
            end
            S_WR: begin
                o_busy      = 1'b1;
                o_mem_wren  = ~i_reset;
                o_mem_addr  = w_addr;
                o_mem_wdata = w_a_lane[r_idx];
            end
            S_RD_LAST, S_ALU: o_busy = 1'b1;
            S_FIN: begin
                o_done   = 1'b1;
                o_vwrite = (r_op != OP_STORE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_op      <= '0;
            r_base    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_cap_idx <= '0;
            r_cap_vld <= 1'b0;
            r_stage   <= '0;
            r_vresult <= '0;
            r_vzero   <= 1'b1;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_op   <= i_op;
                r_base <= i_base_addr;
                r_a    <= i_vsrc1;
                r_b    <= i_vsrc2;
                r_idx  <= '0;
            end else if (r_state == S_RD || r_state == S_WR) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // Read data lags its request by one cycle.
            r_cap_vld <= (r_state == S_RD);
            r_cap_idx <= r_idx;
            if (r_cap_vld) r_stage <= w_load_vec;
            if (r_state == S_RD_LAST) begin
                r_vresult <= w_load_vec;
                r_vzero   <= (w_load_vec == '0);
            end else if (r_state == S_ALU) begin
                r_vresult <= w_alu;
                r_vzero   <= (w_alu == '0);
            end
        end
    end

    assign o_vresult = r_vresult;
    assign o_vzero   = r_vzero;
endmodule

// File: tb/tb_vector_lane_engine.sv
// Bench for vector_lane_engine: wrap and saturating instances side by side,
// per-cycle strobe model plus a result scoreboard drained on vwrite.
module tb_vector_lane_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [7:0]  base = '0;
    logic [31:0] va = '0, vb = '0;

    logic [7:0]  mem_addr, mem_wdata, mem_q, s_mem_addr, s_mem_wdata;
    logic        mem_rden, mem_wren, busy, vwrite, vzero, done;
    logic        s_mem_rden, s_mem_wren, s_busy, s_vwrite, s_vzero, s_done;
    logic [31:0] vresult, s_vresult;
    logic [7:0]  s_mem_q = 8'h00;

    logic [7:0]  mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0, pl_data = '0;

    int n_cmp = 0, n_fail = 0;
    logic [31:0] q0[$], q1[$];

    always #5 clk = ~clk;

    vector_lane_engine #(.LANES(4), .DATA_W(8), .ADDR_W(8), .SATURATE(0)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_base_addr(base),
        .i_vsrc1(va), .i_vsrc2(vb), .o_mem_addr(mem_addr), .o_mem_rden(mem_rden),
        .o_mem_wren(mem_wren), .o_mem_wdata(mem_wdata), .i_mem_q(mem_q), .o_busy(busy),
        .o_vwrite(vwrite), .o_vresult(vresult), .o_vzero(vzero), .o_done(done));

    vector_lane_engine #(.LANES(4), .DATA_W(8), .ADDR_W(8), .SATURATE(1)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_base_addr(base),
        .i_vsrc1(va), .i_vsrc2(vb), .o_mem_addr(s_mem_addr), .o_mem_rden(s_mem_rden),
        .o_mem_wren(s_mem_wren), .o_mem_wdata(s_mem_wdata), .i_mem_q(s_mem_q), .o_busy(s_busy),
        .o_vwrite(s_vwrite), .o_vresult(s_vresult), .o_vzero(s_vzero), .o_done(s_done));

    // Synchronous memory: one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en)         mem[pl_addr] <= pl_data;
        else if (mem_wren) mem[mem_addr] <= mem_wdata;
        if (mem_rden)      mem_q <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each vwrite pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && vwrite) begin
            if (q0.size() == 0) chk("unexpected vwrite", 64'd1, 64'd0);
            else begin
                logic [31:0] e;
                e = q0.pop_front();
                chk("vresult", {32'd0, vresult}, {32'd0, e});
                chk("vzero", {63'd0, vzero}, {63'd0, (e == 32'd0)});
            end
        end
        if (!rst && s_vwrite) begin
            if (q1.size() == 0) chk("unexpected sat vwrite", 64'd1, 64'd0);
            else begin
                logic [31:0] e;
                e = q1.pop_front();
                chk("sat vresult", {32'd0, s_vresult}, {32'd0, e});
                chk("sat vzero", {63'd0, s_vzero}, {63'd0, (e == 32'd0)});
            end
        end
    end

    task automatic pl_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issues one op and checks every strobe cycle by cycle; start_mask bit c
    // re-pulses start so that it is sampled at the end of cycle c.
    task automatic run_op(input logic [1:0] o, input logic [7:0] b, input logic [31:0] a,
                          input logic [31:0] bb, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [15:0] start_mask);
        int lat;
        lat = (o == 2'b00) ? 6 : (o == 2'b01) ? 5 : 2;
        @(negedge clk);
        start = 1'b1; op = o; base = b; va = a; vb = bb;
        if (o != 2'b01) begin q0.push_back(e0); q1.push_back(e1); end
        @(posedge clk); #1;
        // Scramble inputs: the op in flight must use the latched copies.
        start = 1'b0; op = ~o; base = ~b; va = $urandom; vb = $urandom;
        for (int c = 1; c <= lat + 1; c++) begin
            logic rd, wr;
            logic [7:0] ea, ed;
            @(negedge clk);
            rd = (o == 2'b00) && c <= 4;
            wr = (o == 2'b01) && c <= 4;
            ea = (rd || wr) ? b + 8'(c - 1) : 8'h00;
            ed = wr ? a[(c-1)*8 +: 8] : 8'h00;
            chk($sformatf("op%0d cycle%0d strobes{rd,wr,busy,done,vwr,addr,wdata}", o, c),
                {43'd0, mem_rden, mem_wren, busy, done, vwrite, mem_addr, mem_wdata},
                {43'd0, rd, wr, (c < lat), (c == lat), (c == lat && o != 2'b01), ea, ed});
            start = start_mask[c];
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, r_wrap, r_sat;
    } alu_vec_t;
    alu_vec_t tbl [5];

    initial begin
        tbl[0] = '{2'b10, 32'hFF017F80, 32'h01010180, 32'h00028000, 32'hFF0280FF};
        tbl[1] = '{2'b11, 32'h12345678, 32'h12345678, 32'h00000000, 32'h00000000};
        tbl[2] = '{2'b11, 32'h00000005, 32'h00000006, 32'h000000FF, 32'h00000000};
        tbl[3] = '{2'b10, 32'h10203040, 32'h01020304, 32'h11223344, 32'h11223344};
        tbl[4] = '{2'b11, 32'h00FF1000, 32'h01010101, 32'hFFFE0FFF, 32'h00FE0F00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state", {19'd0, mem_rden, mem_wren, busy, done, vwrite, mem_addr, mem_wdata, vresult, vzero},
            {19'd0, 5'b0, 8'h00, 8'h00, 32'h0, 1'b1});
        chk("sat reset state", {31'd0, s_busy, s_vresult, s_vzero}, {31'd0, 1'b0, 32'h0, 1'b1});
        @(posedge clk); #1;
        rst = 1'b0;

        pl_write(8'h10, 8'h11); pl_write(8'h11, 8'h22);
        pl_write(8'h12, 8'h33); pl_write(8'h13, 8'h44);
        run_op(2'b00, 8'h10, 32'h0, 32'h0, 32'h44332211, 32'h0, 16'h0);

        run_op(2'b01, 8'hFE, 32'hDDCCBBAA, 32'h0, 32'h0, 32'h0, 16'h0);
        chk("mem[FE]", {56'd0, mem[8'hFE]}, 64'hAA);
        chk("mem[FF]", {56'd0, mem[8'hFF]}, 64'hBB);
        chk("mem[00]", {56'd0, mem[8'h00]}, 64'hCC);
        chk("mem[01]", {56'd0, mem[8'h01]}, 64'hDD);

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].op, 8'h00, tbl[i].a, tbl[i].b, tbl[i].r_wrap, tbl[i].r_sat, 16'h0);

        // Start re-pulsed in RD and in FIN must be ignored; the next IDLE start is taken.
        pl_write(8'h20, 8'h00); pl_write(8'h21, 8'h80);
        pl_write(8'h22, 8'h01); pl_write(8'h23, 8'hFE);
        run_op(2'b00, 8'h10, 32'h0, 32'h0, 32'h44332211, 32'h0, 16'h0044);
        run_op(2'b00, 8'h20, 32'h0, 32'h0, 32'hFE018000, 32'h0, 16'h0);

        // Reset in cycle 2 of a store: only lane 0 reaches memory.
        for (int k = 0; k < 4; k++) pl_write(8'h40 + 8'(k), 8'h5A);
        @(negedge clk);
        start = 1'b1; op = 2'b01; base = 8'h40; va = 32'h04030201;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rst-store c1 {wren,addr,wdata}", {47'd0, mem_wren, mem_addr, mem_wdata}, {47'd0, 1'b1, 8'h40, 8'h01});
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst-store c2 wren", {63'd0, mem_wren}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("rst-store c%0d {rd,wr,busy,done,vwr}", c),
                {59'd0, mem_rden, mem_wren, busy, done, vwrite}, 64'd0);
        end
        chk("rst-store mem[40]", {56'd0, mem[8'h40]}, 64'h01);
        chk("rst-store mem[41]", {56'd0, mem[8'h41]}, 64'h5A);
        chk("rst-store mem[42]", {56'd0, mem[8'h42]}, 64'h5A);
        chk("rst-store mem[43]", {56'd0, mem[8'h43]}, 64'h5A);
        chk("post-reset vresult/vzero", {31'd0, vresult, vzero}, {31'd0, 32'h0, 1'b1});
        chk("pending results", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
